// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter with a small input FIFO.
// Each frame is start bit, DATA_W data bits sent LSB-first, an optional
// parity bit, then STOP_BITS stop bits. Every bit lasts one i_clk_en period.
// Optional feature: define UART_TX_PARITY_EN to add a parity bit after the
// data bits. PARITY_ODD selects its polarity.
module uart_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);

  // Reject parameter values the frame logic cannot represent.
  if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
  logic                stop_cnt, stop_cnt_n;
  logic                tx_n, busy_n;
  logic                push, pop, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                par, par_n;
`endif

  assign fifo_empty = (count == '0);
  assign o_ready    = (count != CNT_W'(FIFO_DEPTH));
  assign push       = i_valid && o_ready;

  // FIFO storage; written at the write pointer on every accepted push.
  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  // Next-state, datapath and line-level decode; moves only on baud ticks.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    pop        = 1'b0;
    tx_n       = 1'b1;
    busy_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par;
`endif
    if (i_clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = S_START;
          end
        end
        S_START: begin
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end
        S_DATA: begin
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            stop_cnt_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_n    = S_PARITY;
`else
            state_n    = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          stop_cnt_n = 1'b0;
          state_n    = S_STOP;
        end
`endif
        S_STOP: begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (pop) begin
      shift_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      par_n   = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
    end

    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase

    busy_n = (state_n != S_IDLE) || (count_n != '0);
  end

  // State, FIFO pointers and registered outputs; reset abandons any frame.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      o_tx     <= tx_n;
      o_busy   <= busy_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances share clock, reset, tick and data;
// dut uses one stop bit / even parity, dut2 two stop bits / odd parity.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0, valid2 = 1'b0;
  logic       ready, tx, busy;
  logic       ready2, tx2, busy2;
  int         tick_div = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  uart_tx #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_data(data),
    .i_valid(valid), .o_ready(ready), .o_tx(tx), .o_busy(busy));

  uart_tx #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_data(data),
    .i_valid(valid2), .o_ready(ready2), .o_tx(tx2), .o_busy(busy2));

  always #5 clk = ~clk;

  // Baud tick: one-cycle pulse every 10 clocks, changed on the falling edge.
  always @(negedge clk) begin
    if (tick_div == 9) begin
      tick_div = 0;
      clk_en   = 1'b1;
    end else begin
      tick_div = tick_div + 1;
      clk_en   = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  // Advance to 1 time unit after the next active clock edge carrying a tick.
  task automatic next_tick();
    do @(posedge clk); while (!clk_en);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit sel);
    data = d;
    if (sel) valid2 = 1'b1;
    else     valid  = 1'b1;
    @(posedge clk);
    #1;
    valid  = 1'b0;
    valid2 = 1'b0;
  endtask

  // Expect one frame of d, bit by bit, starting at bit index first.
  task automatic check_frame(input string tag, input logic [7:0] d, input bit sel,
                             input int stops, input bit odd, input int first);
    int  nbits;
    logic e;
    nbits = 1 + 8 + P + stops;
    for (int i = first; i < nbits; i++) begin
      next_tick();
      if (i == 0)                e = 1'b0;
      else if (i <= 8)           e = d[i-1];
      else if (P == 1 && i == 9) e = (^d) ^ odd;
      else                       e = 1'b1;
      chk($sformatf("%s_bit%0d", tag, i), 32'(line(sel)), 32'(e));
      if (i == 0) begin
        chk({tag, "_busy"}, 32'(sel ? busy2 : busy), 32'd1);
        chk({tag, "_ready_after_pop"}, 32'(sel ? ready2 : ready), 32'd1);
      end
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("%s_hold%0d", tag, i), 32'(line(sel)), 32'(e));
    end
  endtask

  task automatic check_idle(input string tag, input bit sel);
    next_tick();
    chk({tag, "_tx"}, 32'(line(sel)), 32'd1);
    chk({tag, "_busy"}, 32'(sel ? busy2 : busy), 32'd0);
  endtask

  initial begin
    // Reset values
    #23;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x55
    next_tick();
    push(8'h55, 1'b0);
    chk("single_busy_queued", 32'(busy), 32'd1);
    chk("single_tx_before_tick", 32'(tx), 32'd1);
    check_frame("single55", 8'h55, 1'b0, 1, 1'b0, 0);
    check_idle("single_end", 1'b0);

`ifdef UART_TX_PARITY_EN
    // Parity polarity with 0x07: even gives 1, odd gives 0
    next_tick();
    push(8'h07, 1'b0);
    check_frame("par_even", 8'h07, 1'b0, 1, 1'b0, 0);
    check_idle("par_even_end", 1'b0);
    next_tick();
    push(8'h07, 1'b1);
    check_frame("par_odd", 8'h07, 1'b1, 2, 1'b1, 0);
    check_idle("par_odd_end", 1'b1);
`endif

    // Fill FIFO, fifth push refused, four frames back-to-back
    next_tick();
    push(8'hA1, 1'b0);
    push(8'hB2, 1'b0);
    push(8'hC3, 1'b0);
    chk("fill_ready3", 32'(ready), 32'd1);
    push(8'hD4, 1'b0);
    chk("fill_ready4", 32'(ready), 32'd0);
    push(8'hE5, 1'b0);
    chk("fill_ready5", 32'(ready), 32'd0);
    check_frame("fA1", 8'hA1, 1'b0, 1, 1'b0, 0);
    check_frame("fB2", 8'hB2, 1'b0, 1, 1'b0, 0);
    check_frame("fC3", 8'hC3, 1'b0, 1, 1'b0, 0);
    check_frame("fD4", 8'hD4, 1'b0, 1, 1'b0, 0);
    check_idle("fill_end", 1'b0);
    check_idle("fill_no_e5", 1'b0);

    // Push in the same cycle as a pop with two entries queued
    next_tick();
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    push(8'h33, 1'b0);
    chk("pp_start", 32'(tx), 32'd0);
    push(8'h44, 1'b0);
    chk("pp_ready_cnt3", 32'(ready), 32'd1);
    push(8'h55, 1'b0);
    chk("pp_ready_cnt4", 32'(ready), 32'd0);
    check_frame("p11", 8'h11, 1'b0, 1, 1'b0, 1);
    check_frame("p22", 8'h22, 1'b0, 1, 1'b0, 0);
    check_frame("p33", 8'h33, 1'b0, 1, 1'b0, 0);
    check_frame("p44", 8'h44, 1'b0, 1, 1'b0, 0);
    check_frame("p55", 8'h55, 1'b0, 1, 1'b0, 0);
    check_idle("pp_end", 1'b0);

    // Reset during data bit 3 of 0x00
    next_tick();
    push(8'h00, 1'b0);
    push(8'hF0, 1'b0);
    repeat (5) next_tick();
    chk("mid_bit3", 32'(tx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("mid_flushed", 1'b0);
    push(8'h3C, 1'b0);
    check_frame("post3C", 8'h3C, 1'b0, 1, 1'b0, 0);
    check_idle("post3C_end", 1'b0);

    // Two stop bits between back-to-back frames
    next_tick();
    push(8'hFF, 1'b1);
    push(8'hFF, 1'b1);
    check_frame("s2a", 8'hFF, 1'b1, 2, 1'b1, 0);
    check_frame("s2b", 8'hFF, 1'b1, 2, 1'b1, 0);
    check_idle("s2_end", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter that sits directly downstream of `uart_clock_gen` and consumes its `o_clk_en` baud tick. Parallel bytes enter through a valid/ready handshake into a small FIFO. Each byte is then shifted out on `o_tx` as an LSB-first frame, with every bit lasting exactly one tick period. This block is the TX half of the UART IP library.

## Interface
- `DATA_W`, 8: data bits per frame, 5..9.
- `FIFO_DEPTH`, 4: input FIFO entries; a power of 2, ≥2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Used only with `UART_TX_PARITY_EN`.

Ports:
- `i_sys_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_clk_en`  in  1  baud tick from `uart_clock_gen`; one-cycle pulse per bit period.
- `i_data`  in  DATA_W  byte to send.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  FIFO can accept; equals !full, combinational from the FIFO count.
- `o_tx`  out  1  serial line, registered; idle high.
- `o_busy`  out  1  registered; high while a frame is on the line or the FIFO is non-empty.

## Operation
- **Push:** occurs on any cycle with `i_valid && o_ready`. Data is written at the write pointer and the count is incremented.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **State timing:** every transition happens only on a cycle with `i_clk_en=1`. A state therefore holds `o_tx` for one full tick period.
- **IDLE:**
  - `o_tx=1`.
  - On a tick with FIFO non-empty, pop the head into the shift register and enter START.
  - On a tick with FIFO empty, remain in IDLE.
- **START:** `o_tx=0`. On the next tick, enter DATA with the bit counter at 0.
- **DATA:**
  - `o_tx = shift[0]`.
  - On each tick, shift right and increment the counter.
  - After the tick that ends bit `DATA_W-1`, go to PARITY if enabled, otherwise to STOP.
- **PARITY:** `o_tx` = XOR of the popped byte, inverted when `PARITY_ODD=1`. On the next tick, enter STOP.
- **STOP:**
  - `o_tx=1` for `STOP_BITS` ticks.
  - On the last stop tick with FIFO non-empty: pop and go straight to START, giving back-to-back frames with no idle gap.
  - On the last stop tick with FIFO empty: go to IDLE.
- **Push and pop in the same cycle:** the count stays unchanged; the pointers advance independently.
- **Full FIFO:** `o_ready=0`. Any `i_valid` is ignored and no data is overwritten.
- **Empty FIFO:** no pop occurs. The FSM idles with `o_tx=1`.
- **Pointer wrap:** pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- **`o_busy`:** `(state != IDLE) || (count != 0)`, registered.
- **Reset, including mid-frame:**
  - Asynchronous: `o_tx=1`, `o_busy=0`, FSM=IDLE, pointers and count=0, so `o_ready=1`.
  - A partial frame is abandoned. The line returns high immediately.
- **Baud changes:** the host changes the divisor of `uart_clock_gen` only while `o_busy=0`. A change mid-frame corrupts the frame; the block does not detect this.

## Timing
- **Push-to-line latency:** from a push into an empty FIFO in IDLE to `o_tx` falling is one cycle after the next `i_clk_en` pulse.
- **Per-bit update:** `o_tx` changes exactly one cycle after each `i_clk_en` pulse, because the line is registered.
- **Frame length:** 1 + DATA_W + P + STOP_BITS tick periods, where P=1 with the macro and 0 without.
- **`o_ready` timing:**
  - Falls combinationally in the cycle after the push that fills the FIFO.
  - Rises in the cycle after the pop that frees an entry.
- **Reset response:** all outputs take their reset values asynchronously on `i_rst_n` falling. The first push is accepted in the first clock after `i_rst_n` rises.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is compiled in and one parity bit is sent after the data bits, using the polarity set by `PARITY_ODD`.
- **`UART_TX_PARITY_EN` undefined:** the PARITY state and its logic are absent, DATA goes directly to STOP, and `PARITY_ODD` is ignored.

## Test plan
- **Single byte, no parity:** reset, tick every 10 cycles, push 0x55 with the FIFO empty. `o_tx` must read 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop), each level held 10 cycles. `o_busy` must fall after the stop bit.
- **Parity:** with `UART_TX_PARITY_EN` and `PARITY_ODD=0`, push 0x07. The parity bit must be 1 after data bits 1,1,1,0,0,0,0,0. With `PARITY_ODD=1`, the parity bit must be 0.
- **Fill and back-to-back:** push 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 in consecutive cycles.
  - `o_ready` must be 0 after the 4th push and the 5th byte must not be accepted.
  - The four frames must go out back-to-back with no idle tick between stop and start.
  - After the first pop, `o_ready` must return to 1.
- **Simultaneous push and pop:** with FIFO count=2, push in the same cycle as a pop. The count must stay at 2 and the bytes must be sent in order.
- **Reset mid-frame:** assert `i_rst_n`=0 during DATA bit 3 of 0x00.
  - `o_tx` must go to 1 immediately, with `o_busy=0` and `o_ready=1`.
  - After release, a new push of 0x3C must produce a clean frame.
- **Two stop bits:** with `STOP_BITS=2`, push 0xFF twice. The line must stay high for 2 tick periods between the frames.
